jk_register_bank: RTL and testbench

- Parametrised WIDTH-bit register bank with four modes:
  - per-bit JK flip-flop behaviour,
  - parallel load,
  - bidirectional serial shift,
  - up/down binary count with terminal-count flag.
- Replaces single-bit JK flip-flop instances wherever multi-bit state, counters or shift chains are needed.
- All state updates on the rising clock edge; asynchronous active-high reset.

---
 rtl/jk_register_bank.sv | 59 +++++
 tb/tb_jk_register_bank.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/jk_register_bank.sv
// rtl/jk_register_bank.sv - WIDTH-bit register bank: per-bit JK, parallel load, bidirectional shift, up/down count
module jk_register_bank #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  input  logic             dir,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             ser_out,
  output logic             tc
);

  typedef enum logic [1:0] {
    MODE_JK    = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_SHIFT = 2'b10,
    MODE_COUNT = 2'b11
  } mode_t;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  mode_t            w_mode;

  assign w_mode = mode_t'(mode);

  always_comb begin
    w_next = r_q;
    unique case (w_mode)
      MODE_JK:    w_next = (j & ~r_q) | (~k & r_q);
      MODE_LOAD:  w_next = d;
      MODE_SHIFT: w_next = dir ? {ser_in, r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], ser_in};
      MODE_COUNT: w_next = dir ? r_q - 1'b1 : r_q + 1'b1;
      default:    w_next = r_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RESET_VAL;
    end else if (en) begin
      r_q <= w_next;
    end
  end

  assign q       = r_q;
  assign qbar    = ~r_q;
  assign ser_out = dir ? r_q[0] : r_q[WIDTH-1];
  // Terminal value is all-ones counting up, zero counting down; gated so it can cascade into en.
  assign tc      = en && (w_mode == MODE_COUNT) && (dir ? (r_q == '0) : (&r_q));

endmodule

// File: tb/tb_jk_register_bank.sv
// tb/tb_jk_register_bank.sv - directed self-checking bench for jk_register_bank
module tb_jk_register_bank;

  logic       clk = 1'b0;
  logic       rst4, rst8;
  logic       en;
  logic [1:0] mode;
  logic [3:0] j, k, d;
  logic       dir, ser_in;
  logic [3:0] q4, qbar4;
  logic       ser_out4, tc4;
  logic [7:0] j8, k8, d8;
  logic [7:0] q8, qbar8;
  logic       ser_out8, tc8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  jk_register_bank #(.WIDTH(4), .RESET_VAL(4'b0000)) u_dut4 (
    .clk(clk), .rst(rst4), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .dir(dir), .ser_in(ser_in), .q(q4), .qbar(qbar4), .ser_out(ser_out4), .tc(tc4)
  );

  jk_register_bank #(.WIDTH(8), .RESET_VAL(8'hFF)) u_dut8 (
    .clk(clk), .rst(rst8), .en(en), .mode(mode), .j(j8), .k(k8), .d(d8),
    .dir(dir), .ser_in(ser_in), .q(q8), .qbar(qbar8), .ser_out(ser_out8), .tc(tc8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic [3:0] val);
    en = 1'b1; mode = 2'b01; d = val;
    step();
  endtask

  initial begin
    rst4 = 1'b1; rst8 = 1'b1;
    en = 1'b1; mode = 2'b11; dir = 1'b0; ser_in = 1'b0;
    j = '0; k = '0; d = '0; j8 = '0; k8 = '0; d8 = '0;

    // reset state of both instances, counting up with en high
    #3;
    check("rst4_q",    32'(q4),    32'h0);
    check("rst4_qbar", 32'(qbar4), 32'hF);
    check("rst4_tc",   32'(tc4),   32'h0);
    check("rst8_q",    32'(q8),    32'hFF);
    check("rst8_tc",   32'(tc8),   32'h1);
    step(); step();
    check("rst8_q_edges", 32'(q8),  32'hFF);
    check("rst8_tc_hold", 32'(tc8), 32'h1);
    #2 rst8 = 1'b0;
    step();
    check("rel8_q",  32'(q8),  32'h00);
    check("rel8_tc", 32'(tc8), 32'h0);
    rst4 = 1'b0;

    // async reset between edges
    load4(4'b1011);
    check("load_q", 32'(q4), 32'hB);
    #2 rst4 = 1'b1;
    #1;
    check("async_q",    32'(q4),    32'h0);
    check("async_qbar", 32'(qbar4), 32'hF);
    step(); step();
    check("rst_edges_q", 32'(q4), 32'h0);
    rst4 = 1'b0;

    // JK per bit
    load4(4'b1010);
    mode = 2'b00; j = 4'b1100; k = 4'b1010; d = 4'b1111;
    step();
    check("jk_q", 32'(q4), 32'h4);
    j = 4'b0000; k = 4'b0000;
    step();
    check("jk_hold_q", 32'(q4), 32'h4);

    // shift left then right
    load4(4'b0000);
    mode = 2'b10; dir = 1'b0;
    ser_in = 1'b1; step();
    ser_in = 1'b0; step();
    ser_in = 1'b1; step();
    ser_in = 1'b1; step();
    check("shl_q",       32'(q4),       32'hB);
    check("shl_ser_out", 32'(ser_out4), 32'h1);
    check("shl_tc",      32'(tc4),      32'h0);
    dir = 1'b1; ser_in = 1'b0;
    step();
    check("shr_q",       32'(q4),       32'h5);
    check("shr_ser_out", 32'(ser_out4), 32'h1);

    // count up with wrap, then down
    load4(4'b1110);
    mode = 2'b11; dir = 1'b0;
    step();
    check("up_q1",  32'(q4),  32'hF);
    check("up_tc1", 32'(tc4), 32'h1);
    step();
    check("up_wrap_q",  32'(q4),  32'h0);
    check("up_wrap_tc", 32'(tc4), 32'h0);
    dir = 1'b1;
    #1;
    check("dn_tc0", 32'(tc4), 32'h1);
    step();
    check("dn_wrap_q",  32'(q4),  32'hF);
    check("dn_wrap_tc", 32'(tc4), 32'h0);

    // enable hold
    load4(4'b0111);
    mode = 2'b11; dir = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold_q%0d", i),  32'(q4),  32'h7);
      check($sformatf("hold_tc%0d", i), 32'(tc4), 32'h0);
    end
    en = 1'b1;
    step();
    check("en_q", 32'(q4), 32'h8);

    // en low with all-ones forces tc low
    load4(4'b1111);
    mode = 2'b11; dir = 1'b0;
    #1;
    check("tc_en1", 32'(tc4), 32'h1);
    en = 1'b0;
    #1;
    check("tc_en0", 32'(tc4), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
